// File: rtl/count_sched_pkg.sv
// Shared definitions for the counter scheduler: state encoding, default width
// and the RUN-state watchdog limit.
package count_sched_defs;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    // RUN cycles allowed without a match before the interval is aborted.
    function automatic int wd_limit(input int width, input int slack);
        return (1 << width) + slack;
    endfunction

endpackage

// File: rtl/count_sched_arb.sv
// Winner select between the two requesters. With COUNT_SCHED_RR_EN defined a
// pointer alternates tie priority; otherwise requester 0 always wins ties.
module count_sched_arb (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic adv,
    input  logic last,
    output logic win,
    output logic valid
);

    assign valid = req0 | req1;

`ifdef COUNT_SCHED_RR_EN
    logic ptr;

    // After every finished or aborted interval, ties favour the other requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if (adv) begin
            ptr <= ~last;
        end
    end

    assign win = req1 & (~req0 | ptr);
`else
    logic unused_ok;
    assign unused_ok = ^{clk, rst, adv, last};
    assign win       = req1 & ~req0;
`endif

endmodule

// File: rtl/count_sched.sv
// Shares one free-running up-counter between two requesters; tie-break policy
// selected by COUNT_SCHED_RR_EN (defined: round-robin, undefined: fixed).
module count_sched
    import count_sched_defs::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CLR_CYCLES = 1,
    parameter int WD_SLACK   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] tgt0,
    input  logic             req1,
    input  logic [WIDTH-1:0] tgt1,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             cnt_clr,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic             err,
    output logic             busy
);

    localparam int WD_LIMIT = wd_limit(WIDTH, WD_SLACK);
    localparam int WDW      = $clog2(WD_LIMIT + 1);

    state_t           state;
    logic [WIDTH-1:0] tgt_q;
    logic [1:0]       clr_cnt;
    logic [WDW-1:0]   wd_cnt;
    logic             owner;
    logic             hit;
    logic             wd_exp;
    logic             finish;
    logic             arb_win;
    logic             arb_valid;

    assign hit    = (cnt_in == tgt_q);
    assign wd_exp = (wd_cnt == WDW'(WD_LIMIT - 1));
    assign finish = (state == RUN) && (hit || wd_exp);

    count_sched_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .adv   (finish),
        .last  (owner),
        .win   (arb_win),
        .valid (arb_valid)
    );

    // A match wins over a watchdog expiry landing on the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt_clr <= 1'b1;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            tgt_q   <= '0;
            clr_cnt <= '0;
            wd_cnt  <= '0;
            owner   <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        owner   <= arb_win;
                        gnt0    <= ~arb_win;
                        gnt1    <= arb_win;
                        tgt_q   <= arb_win ? tgt1 : tgt0;
                        clr_cnt <= 2'(CLR_CYCLES);
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt - 2'd1;
                    if (clr_cnt == 2'd1) begin
                        state   <= RUN;
                        cnt_clr <= 1'b0;
                        wd_cnt  <= '0;
                    end
                end
                RUN: begin
                    if (hit) begin
                        state   <= DONE;
                        done0   <= ~owner;
                        done1   <= owner;
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        cnt_clr <= 1'b1;
                    end else if (wd_exp) begin
                        state   <= ABORT;
                        err     <= 1'b1;
                        gnt0    <= 1'b0;
                        gnt1    <= 1'b0;
                        cnt_clr <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DONE, ABORT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    cnt_clr <= 1'b1;
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sched.sv
// Self-checking bench for count_sched: directed latency/arbitration cases plus
// random requests, all compared each cycle against an interval-level model.
module tb_count_sched;

    localparam int W     = 4;
    localparam int CLR   = 1;
    localparam int LIMIT = (1 << W) + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [W-1:0] tgt0 = '0;
    logic [W-1:0] tgt1 = '0;
    logic [W-1:0] cnt_in = '0;
    logic         cnt_clr, gnt0, gnt1, done0, done1, err, busy;

    int   checks = 0;
    int   errors = 0;
    logic freeze = 1'b0;
    logic clrS = 1'b1;

    logic         mActive = 1'b0;
    logic         mFin = 1'b0;
    logic         mOwner = 1'b0;
    int           mAge = 0;
    logic [W-1:0] mTgt = '0;
    logic [6:0]   expOut = 7'b0000001;
`ifdef COUNT_SCHED_RR_EN
    logic         mPtr = 1'b0;
`endif

    count_sched #(.WIDTH(W), .CLR_CYCLES(CLR), .WD_SLACK(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .tgt0    (tgt0),
        .req1    (req1),
        .tgt1    (tgt1),
        .cnt_in  (cnt_in),
        .cnt_clr (cnt_clr),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .done0   (done0),
        .done1   (done1),
        .err     (err),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // External up-counter; freeze models a stuck counter.
    always @(negedge clk) clrS = cnt_clr;
    always @(posedge clk) begin
        #1;
        if (clrS) cnt_in = '0;
        else if (!freeze) cnt_in = cnt_in + 1'b1;
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] outVec();
        return {gnt0, gnt1, done0, done1, err, busy, cnt_clr};
    endfunction

    // Interval model: age counts edges since the grant; expOut bit order
    // {gnt0, gnt1, done0, done1, err, busy, cnt_clr}.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mActive = 1'b0;
            mFin    = 1'b0;
            expOut  = 7'b0000001;
`ifdef COUNT_SCHED_RR_EN
            mPtr    = 1'b0;
`endif
        end else begin
            expOut[4:2] = 3'b000;
            if (mFin) begin
                mFin      = 1'b0;
                expOut[1] = 1'b0;
            end else if (!mActive) begin
                if (req0 || req1) begin
`ifdef COUNT_SCHED_RR_EN
                    mOwner = (req0 && req1) ? mPtr : req1;
`else
                    mOwner = req0 ? 1'b0 : 1'b1;
`endif
                    mTgt    = mOwner ? tgt1 : tgt0;
                    mAge    = 0;
                    mActive = 1'b1;
                    expOut  = {~mOwner, mOwner, 3'b000, 1'b1, 1'b1};
                end
            end else begin
                mAge++;
                if (mAge == CLR) begin
                    expOut[0] = 1'b0;
                end else if (mAge > CLR) begin
                    if (cnt_in == mTgt || mAge - CLR == LIMIT) begin
                        mActive = 1'b0;
                        mFin    = 1'b1;
                        if (cnt_in == mTgt) expOut = {2'b00, ~mOwner, mOwner, 1'b0, 1'b1, 1'b1};
                        else                expOut = {2'b00, 2'b00, 1'b1, 1'b1, 1'b1};
`ifdef COUNT_SCHED_RR_EN
                        mPtr = ~mOwner;
`endif
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("outputs", int'(outVec()), int'(expOut));
        checkOutput("gnt_exclusive", int'(gnt0 & gnt1), 0);
    end

    task automatic resetDut();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", int'(outVec()), 7'b0000001);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // One interval from request to done/err, with literal latency expectation.
    task automatic applyStimulus(input string name, input int who, input logic [W-1:0] tgt,
                                 input bit frz, input int expLat, input bit expErr);
        bit seen = 0;
        bit fin  = 0;
        int n    = 0;
        @(negedge clk);
        freeze = frz;
        if (who == 0) begin req0 = 1'b1; tgt0 = tgt; end
        else          begin req1 = 1'b1; tgt1 = tgt; end
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (gnt0 | gnt1) seen = 1;
        end
        if (!seen) begin
            checkOutput({name, "_grant_timeout"}, 0, 1);
        end else begin
            checkOutput({name, "_gnt"}, int'(who ? gnt1 : gnt0), 1);
            while (!fin && n < 60) begin
                @(negedge clk);
                n++;
                if (n == 1) checkOutput({name, "_clr_released"}, int'(cnt_clr), 0);
                if (done0 | done1 | err) fin = 1;
            end
            checkOutput({name, "_latency"}, n, expLat);
            checkOutput({name, "_err"}, int'(err), int'(expErr));
            checkOutput({name, "_done"}, int'(who ? done1 : done0), int'(!expErr));
        end
        req0 = 1'b0;
        req1 = 1'b0;
        freeze = 1'b0;
        @(negedge clk);
    endtask

    task automatic contendRound(input int round, input int expWin, input int expLat);
        bit seen = 0;
        bit fin  = 0;
        int n    = 0;
        int w    = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (gnt0 | gnt1) seen = 1;
        end
        w = gnt1 ? 1 : 0;
        checkOutput($sformatf("contend%0d_winner", round), seen ? w : -1, expWin);
        while (seen && !fin && n < 60) begin
            @(negedge clk);
            n++;
            if (done0 | done1 | err) fin = 1;
        end
        checkOutput($sformatf("contend%0d_latency", round), n, expLat);
        checkOutput($sformatf("contend%0d_done", round), int'(w ? done1 : done0), 1);
        if (w == 1) req1 = 1'b0; else req0 = 1'b0;
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b1;
    endtask

    task automatic resetMidRun();
        bit doneSeen = 0;
        @(negedge clk);
        req0 = 1'b1;
        tgt0 = 4'd10;
        repeat (5) @(negedge clk);
        checkOutput("midrun_busy", int'(busy), 1);
        #2 rst = 1'b0;
        #1 checkOutput("midrun_reset_outputs", int'(outVec()), 7'b0000001);
        req0 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done0 | err) doneSeen = 1;
        end
        checkOutput("midrun_no_done", int'(doneSeen), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic randomPhase();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (req0 && done0) req0 = 1'b0;
            else if (!req0 && $urandom_range(3) == 0) req0 = 1'b1;
            if (req1 && done1) req1 = 1'b0;
            else if (!req1 && $urandom_range(3) == 0) req1 = 1'b1;
            if ($urandom_range(1) == 1) tgt0 = W'($urandom);
            if ($urandom_range(1) == 1) tgt1 = W'($urandom);
            if ($urandom_range(15) == 0) freeze = ~freeze;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        freeze = 1'b0;
        repeat (25) @(negedge clk);
    endtask

    initial begin
        resetDut();
        applyStimulus("single_t5", 0, 4'd5, 1'b0, 7, 1'b0);
        applyStimulus("edge_t0", 0, 4'd0, 1'b0, 2, 1'b0);
        applyStimulus("edge_t15", 0, 4'd15, 1'b0, 17, 1'b0);
        applyStimulus("req1_t3", 1, 4'd3, 1'b0, 5, 1'b0);
        applyStimulus("watchdog", 0, 4'd4, 1'b1, 19, 1'b1);
        checkOutput("watchdog_idle", int'(busy), 0);
        resetMidRun();

        resetDut();
        tgt0 = 4'd2;
        tgt1 = 4'd3;
        req0 = 1'b1;
        req1 = 1'b1;
`ifdef COUNT_SCHED_RR_EN
        contendRound(0, 0, 4);
        contendRound(1, 1, 5);
        contendRound(2, 0, 4);
`else
        contendRound(0, 0, 4);
        contendRound(1, 0, 4);
        contendRound(2, 0, 4);
`endif
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (25) @(negedge clk);

        randomPhase();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_sched.md
Name: count_sched

Overview:
- Scheduler that shares one free-running 4-bit up-counter between two requesters.
- Each requester asks for a timed interval of N counter increments.
- The block grants one requester at a time, clears the counter, and watches its output until it equals the requested target. It then signals done.
- Sits beside the up-counter in the lab top level. It drives the counter's clear and samples its count output.

Parameters:
- WIDTH, 4: counter and target width.
- CLR_CYCLES, 1: cycles cnt_clr is held high before counting starts (1..3).
- WD_SLACK, 2: extra cycles beyond 2^WIDTH allowed in RUN before the watchdog aborts.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 request; level, held until done0.
- tgt0  input  WIDTH  requester 0 target count; sampled at grant.
- req1  input  1  requester 1 request.
- tgt1  input  WIDTH  requester 1 target count.
- cnt_in  input  WIDTH  counter output; increments by 1 per clk while cnt_clr=0.
- cnt_clr  output  1  high = hold the counter at 0.
- gnt0  output  1  requester 0 owns the counter.
- gnt1  output  1  requester 1 owns the counter.
- done0  output  1  one-cycle pulse: requester 0 interval complete.
- done1  output  1  one-cycle pulse: requester 1 interval complete.
- err  output  1  one-cycle pulse: watchdog abort.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - cnt_clr=1; gnt0=gnt1=done0=done1=err=busy=0.
  - Priority pointer resets to requester 0.
  - Reset mid-interval abandons the interval with no done and no err.
- State machine IDLE -> CLEAR -> RUN -> DONE -> IDLE; all outputs are registered.
- IDLE:
  - cnt_clr=1.
  - If any req is high, pick a winner; on the next edge go to CLEAR.
  - At that edge: assert the winner's gnt, latch its tgt into tgt_q, load clr_cnt=CLR_CYCLES.
- Arbitration:
  - One request pending: it wins.
  - Both pending: the requester indicated by the priority pointer wins.
  - After each DONE or abort, the pointer moves to the other requester.
- CLEAR:
  - cnt_clr=1; clr_cnt decrements each cycle.
  - At 0, go to RUN and drive cnt_clr=0 from that edge.
- RUN:
  - cnt_clr=0; wd_cnt increments each cycle.
  - Compare cnt_in == tgt_q every cycle. On match, go to DONE next edge.
  - tgt_q=0 matches on the first RUN cycle, so the interval is 1 RUN cycle.
  - Nominal latency from grant edge to done pulse is CLR_CYCLES + tgt_q + 1 cycles.
- DONE:
  - Lasts exactly one cycle.
  - done_x=1 for the granted requester; gnt_x drops and cnt_clr=1 on this edge.
  - Next state is IDLE.
- Watchdog:
  - If wd_cnt reaches 2^WIDTH + WD_SLACK in RUN without a match, go to DONE-equivalent ABORT for one cycle.
  - ABORT asserts err=1 with no done pulse, then returns to IDLE.
  - Covers a stuck or skipping counter.
- Request changes:
  - Requester must drop req by the cycle after its done pulse.
  - A req still high in IDLE is a new request.
  - tgt changes after grant are ignored.
  - req dropping during CLEAR/RUN is ignored; the interval completes.
- Simultaneous new requests arriving in DONE are not seen until IDLE.
- gnt0 and gnt1 are never high together.

Optional Feature:
- Macro COUNT_SCHED_RR_EN.
- Defined: round-robin arbitration as described above.
- Undefined:
  - Fixed priority; requester 0 always wins ties.
  - The pointer register is removed.
  - All other behaviour is unchanged.

Decomposition:
- Shared package/header count_sched_defs holds:
  - state encoding: IDLE=0, CLEAR=1, RUN=2, DONE=3, ABORT=4, 3 bits;
  - default WIDTH;
  - the watchdog limit expression.
- One sub-module, count_sched_arb:
  - combinational winner select from req0, req1 and the pointer;
  - pointer register update.
- FSM, timers, and compare stay in count_sched.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> cnt_clr=1, all gnt/done/err/busy=0; assert rst=0 mid-RUN -> immediate IDLE, no done.
- Single request: req0=1, tgt0=5, model counter -> gnt0 next edge, cnt_clr low after 1 CLEAR cycle, done0 pulses 7 cycles after grant, cnt_clr=1 with it.
- Contention (RR_EN): req0 and req1 both high, tgt0=2, tgt1=3 -> gnt0 first, then done0; next interval gnt1, then done1; pointer back to 0.
- Contention, fixed priority: macro off, both held high, re-asserted after each done -> gnt0 wins every time.
- Edge targets: tgt0=0 -> done0 after 1 RUN cycle; tgt0=15 -> done0 at cnt_in=15.
- Watchdog: counter model frozen at 0, tgt0=4 -> err pulse after 18 RUN cycles, no done0, return to IDLE.
